// File: rtl/mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_arbiter
// Purpose  : Shares the single RAM port between the instruction-fetch and the
//            data (load/store) requesters. Runs the MOV/MOC handshake, splits
//            doubleword accesses into two word beats, and rejects misaligned
//            or timed-out accesses with a one-cycle err pulse.
// Ports    : clk, reset (async, active-low)
//            if_req/if_addr -> if_done/if_rdata       fetch requester
//            d_req/d_rw/d_dl/d_addr/d_wdata
//                           -> d_done/d_rdata          data requester
//            err, busy                                 status
//            MOV/RW/DL/ram_addr/ram_wdata -> RAM, ram_rdata/MOC <- RAM
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [1:0]  d_dl,
  input  logic [31:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_done,
  output logic [63:0] d_rdata,
  output logic        err,
  output logic        busy,
  output logic        MOV,
  output logic        RW,
  output logic [1:0]  DL,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        MOC
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_ACC1    = 3'd1;
  localparam logic [2:0] c_GAP     = 3'd2;
  localparam logic [2:0] c_ACC2    = 3'd3;
  localparam logic [2:0] c_FIN     = 3'd4;
  localparam logic [1:0] c_DL_WORD = 2'b10;
  localparam logic [1:0] c_DL_DW   = 2'b11;
  localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic        r_is_data;
  logic        r_rw;
  logic [1:0]  r_dl;
  logic [31:0] r_addr;
  logic [63:0] r_wdata;
  logic [7:0]  r_cnt;
  logic        r_err;
  logic [31:0] r_if_rdata;
  logic [63:0] r_d_rdata;

  logic w_req;
  logic w_misaligned;
  logic w_grant;
  logic w_bad;
  logic w_in_acc;
  logic w_dword;
  logic w_timeout;

  // Requests are not sampled during an err pulse: the rejected requester is
  // still holding its request while it observes err.
  assign w_req = (d_req | if_req) & ~r_err;

  // Alignment of whichever request wins the fixed priority (data first).
  always_comb begin
    w_misaligned = 1'b0;
    if (d_req) begin
      case (d_dl)
        2'b01:   w_misaligned = d_addr[0];
        2'b10:   w_misaligned = |d_addr[1:0];
        2'b11:   w_misaligned = |d_addr[2:0];
        default: w_misaligned = 1'b0;
      endcase
    end else begin
      w_misaligned = |if_addr[1:0];
    end
  end

  assign w_grant   = (r_state == c_IDLE) & w_req & ~w_misaligned;
  assign w_bad     = (r_state == c_IDLE) & w_req & w_misaligned;
  assign w_in_acc  = (r_state == c_ACC1) | (r_state == c_ACC2);
  assign w_dword   = (r_dl == c_DL_DW);
  // A MOC arriving on the last allowed cycle still completes the beat.
  assign w_timeout = w_in_acc & ~MOC & (r_cnt == c_TO_LAST);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: if (w_grant) w_next = c_ACC1;
      c_ACC1: begin
        if (MOC)            w_next = w_dword ? c_GAP : c_FIN;
        else if (w_timeout) w_next = c_IDLE;
      end
      c_GAP:  w_next = c_ACC2;
      c_ACC2: begin
        if (MOC)            w_next = c_FIN;
        else if (w_timeout) w_next = c_IDLE;
      end
      c_FIN:  w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  // Grant latch, timeout counter, error pulse and read-data capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_is_data  <= 1'b0;
      r_rw       <= 1'b1;
      r_dl       <= 2'b00;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_err <= w_bad | w_timeout;

      if (w_grant) begin
        r_is_data <= d_req;
        r_rw      <= d_req ? d_rw : 1'b1;
        r_dl      <= d_req ? d_dl : c_DL_WORD;
        r_addr    <= d_req ? d_addr : if_addr;
        r_wdata   <= d_req ? d_wdata : '0;
      end

      // Counts consecutive MOC-low cycles; cleared outside the access states
      // so each beat starts from zero.
      if (w_in_acc && !MOC) r_cnt <= r_cnt + 8'd1;
      else                  r_cnt <= '0;

      if (w_in_acc && MOC && r_rw) begin
        if (!r_is_data) begin
          r_if_rdata <= ram_rdata;
        end else if (r_state == c_ACC2) begin
          r_d_rdata[31:0] <= ram_rdata;
        end else begin
          case (r_dl)
            2'b00:   r_d_rdata <= {56'h0, ram_rdata[7:0]};
            2'b01:   r_d_rdata <= {48'h0, ram_rdata[15:0]};
            2'b10:   r_d_rdata <= {32'h0, ram_rdata};
            default: r_d_rdata[63:32] <= ram_rdata;
          endcase
        end
      end
    end
  end

  // Output logic
  always_comb begin
    MOV       = w_in_acc;
    busy      = (r_state != c_IDLE);
    if_done   = (r_state == c_FIN) & ~r_is_data;
    d_done    = (r_state == c_FIN) & r_is_data;
    err       = r_err;
    RW        = r_rw;
    DL        = w_dword ? c_DL_WORD : r_dl;
    ram_addr  = (r_state == c_ACC2) ? (r_addr + 32'd4) : r_addr;
    // Doubleword writes send the upper word first, then the lower word.
    ram_wdata = (w_dword && (r_state != c_ACC2)) ? r_wdata[63:32] : r_wdata[31:0];
    if_rdata  = r_if_rdata;
    d_rdata   = r_d_rdata;
  end

endmodule
`default_nettype wire
